// File: rtl/pq_client_arbiter_pkg.sv
// Shared types for the priority-queue client arbiter: op codes, FSM states, stat width.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package pq_arb_pkg;

    typedef enum logic [1:0] {
        ENQ     = 2'd0,
        DEQ     = 2'd1,
        REPLACE = 2'd2,
        RSVD    = 2'd3
    } pq_op_e;

    typedef enum logic {
        ISSUE  = 1'b0,
        SETTLE = 1'b1
    } arb_state_e;

    localparam int STAT_WIDTH = 32;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [STAT_WIDTH-1:0] sat_inc(input logic [STAT_WIDTH-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/pq_client_arbiter_if.sv
// Bundle of client request/response signals plus the queue-facing strobes.
// Latency: n/a (wires only).
// Backpressure: o_req_ready is the per-client grant; a request completes on valid&ready.
//
// Modports: slave = arbiter side, master = clients + queue side.
interface pq_client_arbiter_if #(
    parameter int NUM_CLIENTS = 4,
    parameter int DATA_WIDTH  = 16
);
    localparam int ID_W = $clog2(NUM_CLIENTS);

    // client side
    logic [NUM_CLIENTS-1:0]                 i_req_valid;
    logic [NUM_CLIENTS-1:0][1:0]            i_req_op;
    logic [NUM_CLIENTS-1:0][DATA_WIDTH-1:0] i_req_data;
    logic [NUM_CLIENTS-1:0]                 o_req_ready;
    logic                                   o_rsp_valid;
    logic [ID_W-1:0]                        o_rsp_id;
    logic [DATA_WIDTH-1:0]                  o_rsp_data;
    // queue side
    logic                                   o_pq_wrt;
    logic                                   o_pq_read;
    logic [DATA_WIDTH-1:0]                  o_pq_data;
    logic                                   i_pq_full;
    logic                                   i_pq_empty;
    logic [DATA_WIDTH-1:0]                  i_pq_data;

    modport slave (
        input  i_req_valid, i_req_op, i_req_data, i_pq_full, i_pq_empty, i_pq_data,
        output o_req_ready, o_rsp_valid, o_rsp_id, o_rsp_data,
               o_pq_wrt, o_pq_read, o_pq_data
    );

    modport master (
        output i_req_valid, i_req_op, i_req_data, i_pq_full, i_pq_empty, i_pq_data,
        input  o_req_ready, o_rsp_valid, o_rsp_id, o_rsp_data,
               o_pq_wrt, o_pq_read, o_pq_data
    );

endinterface

// File: rtl/pq_client_arbiter_rr_picker.sv
// Round-robin picker: first set bit of i_elig at or after i_ptr, wrapping.
// Latency: purely combinational.
// Backpressure: none; o_any low when nothing is eligible.
//
// Ports: i_elig (eligibility mask), i_ptr (start index), o_grant (one-hot),
//        o_idx (granted index), o_any (a grant exists).
module rr_picker #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  i_elig,
    input  logic [IW-1:0] i_ptr,
    output logic [N-1:0]  o_grant,
    output logic [IW-1:0] o_idx,
    output logic          o_any
);
    logic [IW:0] pos;

    // Scan offsets from far to near so the nearest eligible client wins last.
    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        pos     = '0;
        for (int off = N - 1; off >= 0; off--) begin
            pos = {1'b0, i_ptr} + (IW+1)'(off);
            if (pos >= (IW+1)'(N)) pos = pos - (IW+1)'(N);
            if (i_elig[pos[IW-1:0]]) begin
                o_grant                = '0;
                o_grant[pos[IW-1:0]]   = 1'b1;
                o_idx                  = pos[IW-1:0];
                o_any                  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pq_client_arbiter.sv
// Shares one systolic min-priority queue among NUM_CLIENTS ENQ/DEQ/REPLACE requesters.
// Latency: grant and queue strobes same cycle; tagged response 1 cycle after grant.
// Backpressure: one grant per issue slot, then SETTLE_CYCLES idle; ineligible requests wait.
//
// Ports: i_CLK, i_RST (sync, active-high), bus (pq_client_arbiter_if.slave).
// Optional: define PQ_ARB_STATS_EN to add o_stat_enq/o_stat_deq/o_stat_stall counters.
module pq_client_arbiter
    import pq_arb_pkg::*;
#(
    parameter int NUM_CLIENTS   = 4,
    parameter int DATA_WIDTH    = 16,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic                  i_CLK,
    input  logic                  i_RST,
    pq_client_arbiter_if.slave    bus
`ifdef PQ_ARB_STATS_EN
    ,
    output logic [STAT_WIDTH-1:0] o_stat_enq,
    output logic [STAT_WIDTH-1:0] o_stat_deq,
    output logic [STAT_WIDTH-1:0] o_stat_stall
`endif
);
    localparam int         ID_W        = $clog2(NUM_CLIENTS);
    localparam logic [2:0] SETTLE_LOAD = 3'(SETTLE_CYCLES - 1);

    arb_state_e             state_q, state_d;
    logic [ID_W-1:0]        rr_ptr_q;
    logic [2:0]             settle_cnt_q;
    logic                   rsp_valid_q;
    logic [ID_W-1:0]        rsp_id_q;
    logic [DATA_WIDTH-1:0]  rsp_data_q;

    logic [NUM_CLIENTS-1:0] elig;
    logic [NUM_CLIENTS-1:0] grant_oh;
    logic [ID_W-1:0]        grant_idx;
    logic                   grant_any;
    pq_op_e                 grant_op;
    logic                   rsvd_pending;

    // Eligibility also folds in state and reset so a grant can only exist in ISSUE.
    always_comb begin
        elig         = '0;
        rsvd_pending = 1'b0;
        for (int c = 0; c < NUM_CLIENTS; c++) begin
            if (bus.i_req_valid[c] && state_q == ISSUE && !i_RST) begin
                case (pq_op_e'(bus.i_req_op[c]))
                    ENQ:          elig[c] = !bus.i_pq_full;
                    DEQ, REPLACE: elig[c] = !bus.i_pq_empty;
                    default:      elig[c] = 1'b0;
                endcase
            end
            if (bus.i_req_valid[c] && pq_op_e'(bus.i_req_op[c]) == RSVD) rsvd_pending = 1'b1;
        end
    end

    rr_picker #(.N(NUM_CLIENTS), .IW(ID_W)) u_rr_picker (
        .i_elig  (elig),
        .i_ptr   (rr_ptr_q),
        .o_grant (grant_oh),
        .o_idx   (grant_idx),
        .o_any   (grant_any)
    );

    assign grant_op = pq_op_e'(bus.i_req_op[grant_idx]);

    // State register plus registered response.
    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            state_q      <= ISSUE;
            rr_ptr_q     <= '0;
            settle_cnt_q <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= '0;
            rsp_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            rsp_valid_q <= grant_any;
            if (grant_any) begin
                rsp_id_q     <= grant_idx;
                rsp_data_q   <= (grant_op == ENQ) ? '0 : bus.i_pq_data;
                rr_ptr_q     <= (grant_idx == ID_W'(NUM_CLIENTS - 1)) ? '0 : grant_idx + 1'b1;
                settle_cnt_q <= SETTLE_LOAD;
            end else if (state_q == SETTLE && settle_cnt_q != 3'd0) begin
                settle_cnt_q <= settle_cnt_q - 3'd1;
            end
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ISSUE:   if (grant_any) state_d = SETTLE;
            SETTLE:  if (settle_cnt_q == 3'd0) state_d = ISSUE;
            default: state_d = ISSUE;
        endcase
    end

    // Output logic: grant and queue strobes are combinational in the issue slot.
    always_comb begin
        bus.o_req_ready = grant_oh;
        bus.o_pq_wrt    = grant_any && (grant_op == ENQ || grant_op == REPLACE);
        bus.o_pq_read   = grant_any && (grant_op == DEQ || grant_op == REPLACE);
        bus.o_pq_data   = grant_any ? bus.i_req_data[grant_idx] : '0;
    end

    assign bus.o_rsp_valid = rsp_valid_q;
    assign bus.o_rsp_id    = rsp_id_q;
    assign bus.o_rsp_data  = rsp_data_q;

    // Op 3 can never be granted; a client presenting it deadlocks itself.
    a_no_rsvd_op: assert property (@(posedge i_CLK) disable iff (i_RST) !rsvd_pending);

`ifdef PQ_ARB_STATS_EN
    logic [STAT_WIDTH-1:0] stat_enq_q, stat_deq_q, stat_stall_q;

    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            stat_enq_q   <= '0;
            stat_deq_q   <= '0;
            stat_stall_q <= '0;
        end else begin
            if (grant_any && (grant_op == ENQ || grant_op == REPLACE))
                stat_enq_q <= sat_inc(stat_enq_q);
            if (grant_any && (grant_op == DEQ || grant_op == REPLACE))
                stat_deq_q <= sat_inc(stat_deq_q);
            if (state_q == ISSUE && |bus.i_req_valid && !grant_any)
                stat_stall_q <= sat_inc(stat_stall_q);
        end
    end

    assign o_stat_enq   = stat_enq_q;
    assign o_stat_deq   = stat_deq_q;
    assign o_stat_stall = stat_stall_q;
`endif

endmodule

// File: tb/tb_pq_client_arbiter.sv
// Directed scoreboard bench for pq_client_arbiter (4 clients, 16-bit keys, settle 1).
// Latency: expects grant in the issue cycle, response one cycle later.
// Backpressure: queue full/empty are driven directly by the bench.
module tb_pq_client_arbiter;
    import pq_arb_pkg::*;

    logic i_CLK;
    logic i_RST;
    int   cyc;
    int   n_checks;
    int   n_fail;

    pq_client_arbiter_if #(.NUM_CLIENTS(4), .DATA_WIDTH(16)) bus ();

`ifdef PQ_ARB_STATS_EN
    logic [STAT_WIDTH-1:0] stat_enq, stat_deq, stat_stall;
`endif

    pq_client_arbiter #(.NUM_CLIENTS(4), .DATA_WIDTH(16), .SETTLE_CYCLES(1)) dut (
        .i_CLK (i_CLK),
        .i_RST (i_RST),
        .bus   (bus)
`ifdef PQ_ARB_STATS_EN
        ,
        .o_stat_enq   (stat_enq),
        .o_stat_deq   (stat_deq),
        .o_stat_stall (stat_stall)
`endif
    );

    typedef struct {
        int          cyc;
        logic [3:0]  ready;
        logic        wrt;
        logic        rd;
        logic [15:0] data;
    } grant_t;

    typedef struct {
        int          cyc;
        logic [1:0]  id;
        logic [15:0] data;
    } rsp_t;

    grant_t gq[$];
    rsp_t   rq[$];

    initial begin
        i_CLK = 1'b0;
        forever #5 i_CLK = ~i_CLK;
    end

    always @(posedge i_CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_grant(input int c, input logic [3:0] rdy, input logic w, input logic r,
                              input logic [15:0] d);
        grant_t g;
        g.cyc = c; g.ready = rdy; g.wrt = w; g.rd = r; g.data = d;
        gq.push_back(g);
    endtask

    task automatic push_rsp(input int c, input logic [1:0] id, input logic [15:0] d);
        rsp_t r;
        r.cyc = c; r.id = id; r.data = d;
        rq.push_back(r);
    endtask

    task automatic set_req(input int c, input logic v, input logic [1:0] op, input logic [15:0] d);
        bus.i_req_valid[c] = v;
        bus.i_req_op[c]    = op;
        bus.i_req_data[c]  = d;
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge i_CLK);
        #1;
    endtask

    // Monitor: compares every grant and every response against the queued expectations.
    always @(negedge i_CLK) begin
        if (bus.o_req_ready != 4'b0000) begin
            if (gq.size() == 0) begin
                chk("unexpected_grant", 32'(bus.o_req_ready), 32'h0);
            end else begin
                grant_t g;
                g = gq.pop_front();
                chk("grant_cycle", 32'(cyc), 32'(g.cyc));
                chk("grant_ready", 32'(bus.o_req_ready), 32'(g.ready));
                chk("grant_pq_wrt", 32'(bus.o_pq_wrt), 32'(g.wrt));
                chk("grant_pq_read", 32'(bus.o_pq_read), 32'(g.rd));
                chk("grant_pq_data", 32'(bus.o_pq_data), 32'(g.data));
            end
        end
        if (bus.o_rsp_valid === 1'b1) begin
            if (rq.size() == 0) begin
                chk("unexpected_rsp", 32'(bus.o_rsp_id), 32'hffff);
            end else begin
                rsp_t r;
                r = rq.pop_front();
                chk("rsp_cycle", 32'(cyc), 32'(r.cyc));
                chk("rsp_id", 32'(bus.o_rsp_id), 32'(r.id));
                chk("rsp_data", 32'(bus.o_rsp_data), 32'(r.data));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int g0;
        cyc = 0; n_checks = 0; n_fail = 0;

        // Reset held two cycles with every client requesting ENQ into an empty queue.
        i_RST          = 1'b1;
        bus.i_pq_full  = 1'b0;
        bus.i_pq_empty = 1'b1;
        bus.i_pq_data  = 16'd0;
        set_req(0, 1'b1, 2'(ENQ), 16'd10);
        set_req(1, 1'b1, 2'(ENQ), 16'd20);
        set_req(2, 1'b1, 2'(ENQ), 16'd30);
        set_req(3, 1'b1, 2'(ENQ), 16'd40);
        wait_cyc(2);
        chk("rst_req_ready", 32'(bus.o_req_ready), 32'h0);
        chk("rst_rsp_valid", 32'(bus.o_rsp_valid), 32'h0);
        chk("rst_rsp_id", 32'(bus.o_rsp_id), 32'h0);
        chk("rst_rsp_data", 32'(bus.o_rsp_data), 32'h0);
        chk("rst_pq_wrt", 32'(bus.o_pq_wrt), 32'h0);
        chk("rst_pq_read", 32'(bus.o_pq_read), 32'h0);
        chk("rst_pq_data", 32'(bus.o_pq_data), 32'h0);

        // Fairness: grants 0,1,2,3 two cycles apart, ENQ responses carry 0.
        g0 = cyc;
        for (int k = 0; k < 4; k++) begin
            push_grant(g0 + 2*k, 4'(1 << k), 1'b1, 1'b0, 16'(10 * (k + 1)));
            push_rsp(g0 + 2*k + 1, 2'(k), 16'd0);
        end
        i_RST = 1'b0;
        wait_cyc(7);
        bus.i_req_valid = 4'b0000;

        // Head ordering: queue {5,9}; client 2 DEQ gets 5, then client 1 DEQ gets 9.
        bus.i_pq_empty = 1'b0;
        bus.i_pq_data  = 16'd5;
        set_req(2, 1'b1, 2'(DEQ), 16'h0077);
        push_grant(cyc + 1, 4'b0100, 1'b0, 1'b1, 16'h0077);
        push_rsp(cyc + 2, 2'd2, 16'd5);
        wait_cyc(2);
        set_req(2, 1'b0, 2'(DEQ), 16'h0077);
        set_req(1, 1'b1, 2'(DEQ), 16'h0055);
        bus.i_pq_data = 16'd9;
        push_grant(cyc + 1, 4'b0010, 1'b0, 1'b1, 16'h0055);
        push_rsp(cyc + 2, 2'd1, 16'd9);
        wait_cyc(2);
        set_req(1, 1'b0, 2'(DEQ), 16'h0055);
        bus.i_pq_empty = 1'b1;
        bus.i_pq_data  = 16'd0;
        set_req(0, 1'b1, 2'(DEQ), 16'h0000);
        for (int k = 0; k < 3; k++) begin
            wait_cyc(1);
            chk("empty_stall_ready", 32'(bus.o_req_ready), 32'h0);
            chk("empty_stall_read", 32'(bus.o_pq_read), 32'h0);
        end

        // Full stall: client 0 ENQ 7 blocked, client 3 DEQ goes first.
        bus.i_pq_full  = 1'b1;
        bus.i_pq_empty = 1'b0;
        bus.i_pq_data  = 16'h0021;
        set_req(0, 1'b1, 2'(ENQ), 16'd7);
        set_req(3, 1'b1, 2'(DEQ), 16'h0033);
        push_grant(cyc, 4'b1000, 1'b0, 1'b1, 16'h0033);
        push_rsp(cyc + 1, 2'd3, 16'h0021);
        wait_cyc(1);
        set_req(3, 1'b0, 2'(DEQ), 16'h0033);
        bus.i_pq_full = 1'b0;
        chk("settle_ready", 32'(bus.o_req_ready), 32'h0);
        chk("settle_pq_wrt", 32'(bus.o_pq_wrt), 32'h0);
        push_grant(cyc + 1, 4'b0001, 1'b1, 1'b0, 16'd7);
        push_rsp(cyc + 2, 2'd0, 16'd0);
        wait_cyc(2);
        set_req(0, 1'b0, 2'(ENQ), 16'd7);

        // Replace: head 3, client 1 REPLACE 8.
        bus.i_pq_data = 16'd3;
        set_req(1, 1'b1, 2'(REPLACE), 16'd8);
        push_grant(cyc + 1, 4'b0010, 1'b1, 1'b1, 16'd8);
        push_rsp(cyc + 2, 2'd1, 16'd3);
        wait_cyc(2);
        set_req(1, 1'b0, 2'(REPLACE), 16'd8);

        // Reset in the grant cycle of client 2: no response, pointer back to 0.
        set_req(2, 1'b1, 2'(ENQ), 16'h0044);
        wait_cyc(1);
        i_RST = 1'b1;
        wait_cyc(1);
        chk("midrst_rsp_valid", 32'(bus.o_rsp_valid), 32'h0);
        chk("midrst_ready", 32'(bus.o_req_ready), 32'h0);
        i_RST = 1'b0;
        set_req(1, 1'b1, 2'(ENQ), 16'h0012);
        push_grant(cyc, 4'b0010, 1'b1, 1'b0, 16'h0012);
        push_rsp(cyc + 1, 2'd1, 16'd0);
        wait_cyc(1);
        bus.i_req_valid = 4'b0000;
        wait_cyc(4);

        chk("grant_queue_drained", 32'(gq.size()), 32'h0);
        chk("rsp_queue_drained", 32'(rq.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pq_client_arbiter.md
Name: pq_client_arbiter

Overview:
- Shares one systolic min-priority-queue instance between NUM_CLIENTS requesters.
- Each client issues ENQ / DEQ / REPLACE requests through a valid/ready handshake.
- Grants at most one request per issue slot, round-robin among eligible clients.
- Drives the queue's i_wrt/i_read/i_data, waits out the queue's sort-settle time, and returns a tagged response carrying the dequeued head.

Parameters:
- NUM_CLIENTS, 4, number of requesters (2..16).
- DATA_WIDTH, 16, key width; must match the queue.
- SETTLE_CYCLES, 1, idle cycles after every issued op before the next grant (1..4).

Ports:
- i_CLK  in  1  clock.
- i_RST  in  1  synchronous reset, active-high.
- i_req_valid  in  NUM_CLIENTS  per-client request valid.
- i_req_op  in  NUM_CLIENTS x 2  per-client op: 0=ENQ, 1=DEQ, 2=REPLACE, 3=reserved.
- i_req_data  in  NUM_CLIENTS x DATA_WIDTH  per-client key (ENQ/REPLACE).
- o_req_ready  out  NUM_CLIENTS  one-hot grant; handshake completes when valid&ready.
- o_rsp_valid  out  1  response strobe, one cycle.
- o_rsp_id  out  $clog2(NUM_CLIENTS)  granted client index.
- o_rsp_data  out  DATA_WIDTH  head popped (DEQ/REPLACE); 0 for ENQ.
- o_pq_wrt  out  1  to queue i_wrt.
- o_pq_read  out  1  to queue i_read.
- o_pq_data  out  DATA_WIDTH  to queue i_data.
- i_pq_full  in  1  from queue o_full.
- i_pq_empty  in  1  from queue o_empty.
- i_pq_data  in  DATA_WIDTH  from queue o_data (current head).

Behaviour:
- Reset (i_RST high at edge):
  - State=ISSUE, rr pointer=0, settle counter=0.
  - All outputs 0: o_req_ready, o_rsp_valid, o_rsp_id, o_rsp_data, o_pq_wrt, o_pq_read, o_pq_data.
  - Reset mid-operation drops any in-flight response. The queue is reset separately by its owner.
- Eligibility, evaluated combinationally in ISSUE:
  - ENQ needs !i_pq_full.
  - DEQ needs !i_pq_empty.
  - REPLACE needs !i_pq_empty.
  - Op 3 is never eligible and stalls forever. Assertion fires under simulation.
  - Ineligible requests are not granted and stay pending; no error response.
- Grant:
  - In ISSUE, pick the first eligible client at or after the rr pointer, with wrap-around.
  - o_req_ready is asserted combinationally for that client only, in the same cycle.
  - The queue is driven combinationally in the same cycle:
    - ENQ: wrt=1, read=0.
    - DEQ: wrt=0, read=1.
    - REPLACE: wrt=1, read=1.
    - o_pq_data = client key.
  - No eligible request: no grant, queue strobes 0.
- On the grant edge:
  - Register o_rsp_valid=1, o_rsp_id=client, o_rsp_data = i_pq_data sampled in the grant cycle (0 for ENQ).
  - rr pointer <- client+1 mod NUM_CLIENTS.
  - State -> SETTLE, counter <- SETTLE_CYCLES-1.
- Latency: response one cycle after grant; o_rsp_valid is high exactly one cycle.
- SETTLE state:
  - No ready asserted, queue strobes 0.
  - Counter decrements each cycle; at 0 the next state is ISSUE.
  - Minimum grant-to-grant spacing is SETTLE_CYCLES+1. This guarantees the queue head and full/empty are updated before the next op.
- Clients may change op/data/valid while not granted. After a grant, a client may present a new request next cycle; it is considered only after SETTLE.
- The arbiter does not track size; full/empty come solely from the queue.

Optional Feature:
- Macro PQ_ARB_STATS_EN.
- Defined: adds outputs o_stat_enq, o_stat_deq, o_stat_stall (32-bit each, saturating at all-ones, cleared on i_RST).
  - o_stat_enq counts ENQ+REPLACE grants.
  - o_stat_deq counts DEQ+REPLACE grants.
  - o_stat_stall counts ISSUE cycles where any valid request existed but none was eligible.
- Undefined: ports and counters absent; otherwise identical behaviour.

Decomposition:
- Package pq_arb_pkg holds:
  - pq_op_e enum (ENQ, DEQ, REPLACE, RSVD).
  - arb_state_e enum (ISSUE, SETTLE).
  - STAT_WIDTH=32.
- Sub-module rr_picker: inputs eligibility mask and pointer; outputs one-hot grant, index and any_grant. Purely combinational, reused elsewhere.

Test Plan:
- Reset: hold i_RST 2 cycles with all valids high -> all outputs 0; after release, first grant goes to client 0.
- Fairness: 4 clients all ENQ keys 10,20,30,40 continuously, queue empty, SETTLE_CYCLES=1 -> grants 0,1,2,3 at cycles 0,2,4,6; o_rsp_data=0 each.
- Head ordering: queue holds {5,9}; client 2 DEQ -> rsp id=2 data=5. After settle, client 1 DEQ -> data=9. i_pq_empty=1 -> further DEQ stalls, ready stays 0.
- Full stall: i_pq_full=1, client 0 ENQ 7 and client 3 DEQ pending -> client 3 granted, client 0 waits. Full drops next ISSUE -> client 0 granted, o_pq_data=7.
- Replace: head=3, client 1 REPLACE 8 -> o_pq_wrt=o_pq_read=1, o_pq_data=8, rsp data=3 one cycle later.
- Reset mid-op: assert i_RST in the grant cycle -> no o_rsp_valid next cycle; state ISSUE, pointer 0.
